// File: rtl/qmult_rr_arbiter.sv
// Round-robin front end for one shared pipelined signed Q-format multiplier.
// Results come back a fixed PIPE_STAGES cycles after the handshake, tagged with a one-hot owner.
module qmult_rr_arbiter #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int NUM_REQ         = 4,
    parameter int PIPE_STAGES     = 2,
    localparam int DATA_WIDTH     = INTEGER_BITS + FRACTIONAL_BITS
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               cfg_mask_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_data_o,
    output logic                             busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic signed [2*DATA_WIDTH-1:0] ROUND_K =
        {{(2*DATA_WIDTH-1){1'b0}}, 1'b1} << (FRACTIONAL_BITS - 1);

    logic [PTR_W-1:0]      ptr_reg;
    logic [PTR_W-1:0]      ptr_next;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W:0]        scan_sum;
    logic                  grant_found;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    logic [DATA_WIDTH-1:0]           mul_a;
    logic [DATA_WIDTH-1:0]           mul_b;
    logic signed [2*DATA_WIDTH-1:0]  prod_full;
    logic [DATA_WIDTH-1:0]           rounded_q;
    logic                            unused_prod_bits;
    logic [DATA_WIDTH-1:0]           rsp_data_q;

    logic [NUM_REQ-1:0]    tag_reg [PIPE_STAGES];

    // Unpack the flat operand buses into per-requester words.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi] = req_b_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign eligible = req_valid_i & cfg_mask_i;

    // Scan upward from the pointer, wrapping modulo NUM_REQ; first eligible index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_sum = {1'b0, ptr_reg} + (PTR_W + 1)'(off);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (!grant_found && eligible[scan_sum[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[PTR_W-1:0];
            end
        end
        if (rst_i) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
            ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    assign req_ready_o = grant;
    assign sel_a       = a_arr[grant_idx];
    assign sel_b       = b_arr[grant_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Tag pipeline: a one-hot owner per stage, zero when the stage is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            tag_reg[0] <= grant;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    // Round half toward +inf, then keep the Q-format window; upper bits wrap.
    assign prod_full        = $signed(mul_a) * $signed(mul_b) + ROUND_K;
    assign rounded_q        = prod_full[FRACTIONAL_BITS +: DATA_WIDTH];
    assign unused_prod_bits = ^{prod_full[2*DATA_WIDTH-1:DATA_WIDTH+FRACTIONAL_BITS],
                                prod_full[FRACTIONAL_BITS-1:0]};

    generate
        if (PIPE_STAGES == 1) begin : g_single
            // Multiply straight from the granted operands into the only stage.
            assign mul_a = sel_a;
            assign mul_b = sel_b;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rsp_data_q <= '0;
                end else if (grant_found) begin
                    rsp_data_q <= rounded_q;
                end
            end
        end else begin : g_multi
            logic [DATA_WIDTH-1:0] op_a_reg;
            logic [DATA_WIDTH-1:0] op_b_reg;
            logic [DATA_WIDTH-1:0] res_reg [PIPE_STAGES-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    op_a_reg <= '0;
                    op_b_reg <= '0;
                end else if (grant_found) begin
                    op_a_reg <= sel_a;
                    op_b_reg <= sel_b;
                end
            end

            assign mul_a = op_a_reg;
            assign mul_b = op_b_reg;

            // Result stages only load behind a valid stage, so the output holds between responses.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int s = 0; s < PIPE_STAGES - 1; s++) begin
                        res_reg[s] <= '0;
                    end
                end else begin
                    if (|tag_reg[0]) begin
                        res_reg[0] <= rounded_q;
                    end
                    for (int s = 1; s < PIPE_STAGES - 1; s++) begin
                        if (|tag_reg[s]) begin
                            res_reg[s] <= res_reg[s-1];
                        end
                    end
                end
            end

            assign rsp_data_q = res_reg[PIPE_STAGES-2];
        end
    endgenerate

    assign rsp_valid_o = tag_reg[PIPE_STAGES-1];
    assign rsp_data_o  = rsp_data_q;

    always_comb begin
        busy_o = 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            busy_o = busy_o | (|tag_reg[s]);
        end
    end

endmodule

// File: tb/tb_qmult_rr_arbiter.sv
// Randomized scoreboard bench for qmult_rr_arbiter: stimulus predicts grants and results,
// an independent monitor matches every response against the expected queue.
module tb_qmult_rr_arbiter;

    localparam int IB = 8;
    localparam int FB = 24;
    localparam int N  = 4;
    localparam int P  = 2;
    localparam int W  = IB + FB;

    logic             clk_i;
    logic             rst_i;
    logic [N-1:0]     cfg_mask_i;
    logic [N-1:0]     req_valid_i;
    logic [N*W-1:0]   req_a_i;
    logic [N*W-1:0]   req_b_i;
    logic [N-1:0]     req_ready_o;
    logic [N-1:0]     rsp_valid_o;
    logic [W-1:0]     rsp_data_o;
    logic             busy_o;

    qmult_rr_arbiter #(
        .INTEGER_BITS(IB),
        .FRACTIONAL_BITS(FB),
        .NUM_REQ(N),
        .PIPE_STAGES(P)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cfg_mask_i(cfg_mask_i),
        .req_valid_i(req_valid_i),
        .req_a_i(req_a_i),
        .req_b_i(req_b_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o),
        .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cycle = 0;
    always @(posedge clk_i) cycle <= cycle + 1;

    typedef struct {
        logic [N-1:0] tag;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passed = 0;

    int m_ptr      = 0;
    int m_last_hs  = -1000;
    bit post_reset = 1'b0;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endfunction

    // Signed Q multiply: exact 64-bit product, add half an LSB, arithmetic shift, wrap to W bits.
    function automatic logic [W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p + (longint'(1) << (FB - 1));
        q = p >>> FB;
        return W'(q);
    endfunction

    function automatic int model_grant(input logic [N-1:0] elig);
        for (int off = 0; off < N; off++) begin
            int idx = (m_ptr + off) % N;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] valid, input logic [N-1:0] mask);
        int g;
        logic [N-1:0] exp_ready;
        exp_t e;
        @(posedge clk_i);
        if (rst_i === 1'b1) begin
            sb.delete();
            m_ptr      = 0;
            m_last_hs  = -1000;
            post_reset = 1'b1;
        end
        #1;
        rst_i       = rst;
        req_valid_i = valid;
        cfg_mask_i  = mask;
        for (int k = 0; k < N; k++) begin
            req_a_i[k*W +: W] = op_a[k];
            req_b_i[k*W +: W] = op_b[k];
        end
        @(negedge clk_i);
        g = rst ? -1 : model_grant(valid & mask);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready_o, exp_ready);
        chk("busy", busy_o, ((cycle - m_last_hs) <= P) ? 1 : 0);
        if (post_reset) begin
            chk("reset_rsp_valid", rsp_valid_o, 0);
            chk("reset_rsp_data", rsp_data_o, 0);
            post_reset = 1'b0;
        end
        if (g >= 0) begin
            e.tag  = exp_ready;
            e.data = model_mul(op_a[g], op_b[g]);
            e.due  = cycle + P;
            sb.push_back(e);
            m_last_hs = cycle;
            m_ptr     = (g + 1) % N;
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            op_a[k] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            op_b[k] = ($urandom_range(0, 3) == 0) ? W'(-$urandom_range(0, 255)) : W'($urandom);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation, on its due cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (rsp_valid_o !== '0) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL rsp_unexpected: got tag %b data %h expected no response at cycle %0d",
                         rsp_valid_o, rsp_data_o, cycle);
            end else begin
                e = sb.pop_front();
                $display("rsp cycle=%0d tag=%b data=%h", cycle, rsp_valid_o, rsp_data_o);
                chk("rsp_tag", rsp_valid_o, e.tag);
                chk("rsp_data", rsp_data_o, e.data);
                chk("rsp_cycle", cycle, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            checks++;
            $display("FAIL rsp_missing: got no response expected tag %b data %h due cycle %0d",
                     e.tag, e.data, e.due);
        end
    end

    initial begin
        rst_i       = 1'b1;
        cfg_mask_i  = '0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        for (int k = 0; k < N; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end

        step(1'b1, 4'b0000, 4'b1111);
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b0, 4'b0000, 4'b1111);
        step(1'b0, 4'b0000, 4'b1111);

        // Single op then the rounding/sign/wrap vectors, all from requester 0.
        op_a[0] = 32'h0180_0000; op_b[0] = 32'h0200_0000;
        step(1'b0, 4'b0001, 4'b1111);
        for (int i = 0; i < P + 1; i++) step(1'b0, 4'b0000, 4'b1111);
        op_a[0] = 32'h0000_0001; op_b[0] = 32'h0080_0000;
        step(1'b0, 4'b0001, 4'b1111);
        op_a[0] = 32'hFF00_0000; op_b[0] = 32'h0080_0000;
        step(1'b0, 4'b0001, 4'b1111);
        op_a[0] = 32'h1000_0000; op_b[0] = 32'h1000_0000;
        step(1'b0, 4'b0001, 4'b1111);
        for (int i = 0; i < P + 1; i++) step(1'b0, 4'b0000, 4'b1111);

        // Fairness from a fresh pointer.
        step(1'b1, 4'b0000, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step(1'b0, 4'b1111, 4'b1111);
        end

        // Masked requesters 0 and 2 stay valid but must never be granted.
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            step(1'b0, 4'b1111, 4'b1010);
        end
        for (int i = 0; i < P + 1; i++) step(1'b0, 4'b0000, 4'b1111);

        // Sparse: requester 2 alone, then requester 0 alone.
        step(1'b1, 4'b0000, 4'b1111);
        rand_ops();
        step(1'b0, 4'b0100, 4'b1111);
        step(1'b0, 4'b0001, 4'b1111);
        step(1'b0, 4'b0010, 4'b1111);

        // Reset with products in flight; next grant must go to the lowest eligible.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(1'b0, 4'b1111, 4'b1111);
        end
        step(1'b1, 4'b1111, 4'b1111);
        step(1'b0, 4'b0110, 4'b1111);
        for (int i = 0; i < P + 1; i++) step(1'b0, 4'b0000, 4'b1111);

        // Randomized traffic with occasional masks and resets.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 N'($urandom),
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : '1);
        end

        for (int i = 0; i < P + 4; i++) step(1'b0, 4'b0000, 4'b1111);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/qmult_rr_arbiter.md
Name: qmult_rr_arbiter

Overview:
- Shares one pipelined signed fixed-point multiplier between NUM_REQ requesters using round-robin arbitration.
- Requesters present operand pairs with a valid/ready handshake.
- Each result returns after a fixed latency on a shared data bus, with a one-hot valid that identifies the owning requester.
- Sits between the iteration/evaluation engines and the single multiplier resource, so multiplier count stays at one per cluster.

Parameters:
- INTEGER_BITS, 8, integer bits of the signed Q format (including sign).
- FRACTIONAL_BITS, 24, fractional bits of the Q format.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- PIPE_STAGES, 2, handshake-to-response latency in cycles; legal range 1..4.
- DATA_WIDTH (localparam), INTEGER_BITS+FRACTIONAL_BITS.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- cfg_mask_i  in  NUM_REQ  per-requester enable; a masked requester is never granted.
- req_valid_i  in  NUM_REQ  operand pair valid, one bit per requester.
- req_a_i  in  NUM_REQ*DATA_WIDTH  operand A, requester k in slice [k*DATA_WIDTH +: DATA_WIDTH].
- req_b_i  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- req_ready_o  out  NUM_REQ  one-hot-or-zero grant; handshake = valid&ready in the same cycle.
- rsp_valid_o  out  NUM_REQ  one-hot-or-zero; the result belongs to the requester whose bit is set.
- rsp_data_o  out  DATA_WIDTH  signed Q result.
- busy_o  out  1  high while any product is in flight in the pipeline.

Behaviour:
- Reset (synchronous, rst_i high at the clock edge):
  - req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0.
  - Round-robin pointer = 0.
  - All pipeline valid bits cleared; in-flight products are discarded and never delivered.
- Grant logic:
  - Combinational from req_valid_i & cfg_mask_i and the registered pointer.
  - Grant goes to the first eligible index at or after the pointer, scanning upward modulo NUM_REQ.
  - At most one grant per cycle. req_ready_o is 0 everywhere when nothing is eligible.
  - req_ready_o is forced to 0 while rst_i is high.
  - A requester's ready may depend on its own valid; requesters must not make valid depend on ready.
- Pointer update:
  - On a handshake with index g, the pointer becomes (g+1) mod NUM_REQ.
  - With no handshake, the pointer holds.
  - Wrap from NUM_REQ-1 goes to 0.
- Throughput: one handshake per cycle, sustained. The pipeline never stalls and responses are not backpressured.
- Latency:
  - A handshake at edge t puts the result on rsp_data_o with rsp_valid_o[g]=1 during the cycle after edge t+PIPE_STAGES-1.
  - That is exactly PIPE_STAGES cycles after the handshake cycle.
  - The result is held for exactly one cycle.
  - When no response is due, rsp_valid_o=0 and rsp_data_o holds its last value.
- Arithmetic:
  - Full 2*DATA_WIDTH signed product.
  - Add 2^(FRACTIONAL_BITS-1) (round half toward +inf).
  - Output bits [DATA_WIDTH+FRACTIONAL_BITS-1 : FRACTIONAL_BITS].
  - No saturation: overflow wraps two's-complement.
- Pipeline stages:
  - Stage 1 registers the operands and tag.
  - Stages 2..PIPE_STAGES carry the product and tag.
  - When PIPE_STAGES=1, product, rounding and slicing all occur within that single stage.
- busy_o = OR of all pipeline valid bits; it does not include the current-cycle grant.
- cfg_mask_i takes effect combinationally on grants. Clearing a bit does not cancel that requester's in-flight products.
- Simultaneous events:
  - The same requester may hold valid every cycle. Under contention it receives every NUM_REQ-th eligible slot.
  - A new handshake and a response delivery in the same cycle are independent.

Test Plan:
- Single op: req 0 sends a=0x01800000 (1.5), b=0x02000000 (2.0) at cycle 5 → rsp_valid_o=0001 and rsp_data_o=0x03000000 at cycle 5+PIPE_STAGES; busy_o high for PIPE_STAGES cycles.
- Rounding and sign:
  - a=0x00000001, b=0x00800000 → 0x00000001.
  - a=0xFF000000 (-1.0), b=0x00800000 → 0xFF800000.
  - a=0x10000000, b=0x10000000 (16*16) → wraps to 0x00000000.
- Round-robin fairness: all four requesters hold valid for 8 cycles starting with pointer=0 → grant order 0,1,2,3,0,1,2,3; responses arrive in that order with matching one-hot tags, back-to-back.
- Mask and pointer wrap: cfg_mask_i=1010, requesters 1 and 3 valid → grants alternate 1,3,1,3; requesters 0 and 2 never see ready, even when valid.
- Sparse requests: only requester 2 valid, then only requester 0 one cycle later → grants 2 then 0; pointer goes 3 then 1.
- Reset mid-operation: three products in flight with rst_i high for 1 cycle → no rsp_valid_o for those products, busy_o=0, pointer=0; the next grant goes to the lowest eligible index.
